writeback_arb: RTL and testbench



---
 rtl/writeback_arb.sv | 145 ++++++++++++++
 tb/tb_writeback_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arb.sv
// writeback_arb: per-channel in-order result FIFOs drained round-robin to one RF write port.
// Ports: clk, rst (sync, active-high); per channel v_i, stall_o, wb_i, rd_num_i, rd_data_i;
//        write port wb_o, wbr_num_o, wb_data_o, wb_ch_o. Option macro: WB_BYPASS_EN.
module writeback_arb #(
  parameter int N_CH  = 2,
  parameter int DEPTH = 2,
  parameter int W_RD  = 5,
  parameter int WORD  = 32,
  localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      v_i,
  output logic [N_CH-1:0]      stall_o,
  input  logic [N_CH-1:0]      wb_i,
  input  logic [N_CH*W_RD-1:0] rd_num_i,
  input  logic [N_CH*WORD-1:0] rd_data_i,
  output logic                 wb_o,
  output logic [W_RD-1:0]      wbr_num_o,
  output logic [WORD-1:0]      wb_data_o,
  output logic [CHW-1:0]       wb_ch_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [PW-1:0]   wp_q  [N_CH];
  logic [PW-1:0]   wp_d  [N_CH];
  logic [PW-1:0]   rp_q  [N_CH];
  logic [PW-1:0]   rp_d  [N_CH];
  logic [W_RD-1:0] num_q [N_CH][DEPTH];
  logic [W_RD-1:0] num_d [N_CH][DEPTH];
  logic [WORD-1:0] dat_q [N_CH][DEPTH];
  logic [WORD-1:0] dat_d [N_CH][DEPTH];
  logic [CHW-1:0]  p_q;
  logic [CHW-1:0]  p_d;

  logic [N_CH-1:0] acc;
  logic [N_CH-1:0] useful;
  logic [N_CH-1:0] cand;
  logic [N_CH-1:0] byp;
  logic [N_CH-1:0] push;
  logic [N_CH-1:0] pop;
  logic            gnt_vld;
  logic [CHW-1:0]  gnt;
  logic [CHW-1:0]  sel;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] x
  );
    return (x == PW'(DEPTH - 1)) ? '0 : x + 1'b1;
  endfunction

  // Full refuses everything, even when popping this cycle.
  always_comb begin
    stall_o = '0;
    for (int c = 0; c < N_CH; c++) begin
      stall_o[c] = (cnt_q[c] == CW'(DEPTH));
    end
  end

  always_comb begin
    acc    = v_i & ~stall_o & {N_CH{~rst}};
    useful = '0;
    cand   = '0;
    byp    = '0;
    for (int c = 0; c < N_CH; c++) begin
      useful[c] = acc[c] & wb_i[c] &
                  (rd_num_i[c*W_RD +: W_RD] != '0);
      cand[c]   = (cnt_q[c] != '0);
`ifdef WB_BYPASS_EN
      byp[c]    = useful[c] & (cnt_q[c] == '0);
`endif
    end
    cand = cand | byp;

    // Round-robin search starting at p.
    gnt_vld = 1'b0;
    gnt     = '0;
    sel     = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel = CHW'((int'(p_q) + i) % N_CH);
      if (!gnt_vld && cand[sel]) begin
        gnt_vld = 1'b1;
        gnt     = sel;
      end
    end
    gnt_vld = gnt_vld & ~rst;

    wb_o      = 1'b0;
    wbr_num_o = '0;
    wb_data_o = '0;
    wb_ch_o   = '0;
    if (gnt_vld) begin
      wb_o    = 1'b1;
      wb_ch_o = gnt;
      if (byp[gnt]) begin
        wbr_num_o = rd_num_i[int'(gnt)*W_RD +: W_RD];
        wb_data_o = rd_data_i[int'(gnt)*WORD +: WORD];
      end else begin
        wbr_num_o = num_q[gnt][rp_q[gnt]];
        wb_data_o = dat_q[gnt][rp_q[gnt]];
      end
    end

    p_d = gnt_vld ? CHW'((int'(gnt) + 1) % N_CH) : p_q;

    num_d = num_q;
    dat_d = dat_q;
    push  = '0;
    pop   = '0;
    for (int c = 0; c < N_CH; c++) begin
      pop[c]  = gnt_vld & (gnt == CHW'(c)) & ~byp[c];
      // A bypassed result already went out; do not queue it.
      push[c] = useful[c] &
                ~(gnt_vld & (gnt == CHW'(c)) & byp[c]);
      cnt_d[c] = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
      wp_d[c]  = push[c] ? nxt(wp_q[c]) : wp_q[c];
      rp_d[c]  = pop[c] ? nxt(rp_q[c]) : rp_q[c];
      if (push[c]) begin
        num_d[c][wp_q[c]] = rd_num_i[c*W_RD +: W_RD];
        dat_d[c][wp_q[c]] = rd_data_i[c*WORD +: WORD];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
      wp_q  <= '{default: '0};
      rp_q  <= '{default: '0};
      p_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      p_q   <= p_d;
    end
    num_q <= num_d;
    dat_q <= dat_d;
  end

endmodule

// File: tb/tb_writeback_arb.sv
// tb_writeback_arb: directed vectors plus a contention sequence for writeback_arb.
// Default build (N_CH=2, DEPTH=2, no bypass).
module tb_writeback_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  v_i;
  logic [1:0]  stall_o;
  logic [1:0]  wb_i;
  logic [9:0]  rd_num_i;
  logic [63:0] rd_data_i;
  logic        wb_o;
  logic [4:0]  wbr_num_o;
  logic [31:0] wb_data_o;
  logic        wb_ch_o;

  always #5 clk = ~clk;

  writeback_arb #(
    .N_CH(2), .DEPTH(2), .W_RD(5), .WORD(32)
  ) dut (
    .clk(clk), .rst(rst),
    .v_i(v_i), .stall_o(stall_o),
    .wb_i(wb_i), .rd_num_i(rd_num_i),
    .rd_data_i(rd_data_i), .wb_o(wb_o),
    .wbr_num_o(wbr_num_o), .wb_data_o(wb_data_o),
    .wb_ch_o(wb_ch_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  v;
    logic [1:0]  wb;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        ew;
    logic [4:0]  en;
    logic [31:0] ed;
    logic        ec;
    logic [1:0]  es;
    logic        ck_s;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t mk(
    logic r, logic [1:0] v, logic [1:0] wb,
    logic [4:0] r0, logic [31:0] d0,
    logic [4:0] r1, logic [31:0] d1,
    logic ew, logic [4:0] en, logic [31:0] ed,
    logic ec, logic [1:0] es, logic ck_s
  );
    vec_t t;
    t.rst = r;  t.v = v;   t.wb = wb;
    t.r0 = r0;  t.d0 = d0; t.r1 = r1; t.d1 = d1;
    t.ew = ew;  t.en = en; t.ed = ed;
    t.ec = ec;  t.es = es; t.ck_s = ck_s;
    return t;
  endfunction

  int  nacc[2];
  int  nwr[2];
  int  mc[2];
  bit  a[2];
  int  tot;
  int  cyc;
  bit  seen;
  int  ch;

  initial begin
    rst       = 1'b1;
    v_i       = '0;
    wb_i      = '0;
    rd_num_i  = '0;
    rd_data_i = '0;

    // reset, single channel, filtering
    tv[0]  = mk(1, 2'b11, 2'b11, 3, 32'h1, 4, 32'h2,
                0, 0, 0, 0, 2'b00, 1);
    tv[1]  = mk(1, 2'b11, 2'b11, 3, 32'h1, 4, 32'h2,
                0, 0, 0, 0, 2'b00, 1);
    tv[2]  = mk(0, 2'b11, 2'b11, 5, 32'hDEADBEEF,
                6, 32'h11111111,
                0, 0, 0, 0, 2'b00, 1);
    tv[3]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0,
                1, 5, 32'hDEADBEEF, 0, 2'b00, 1);
    tv[4]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0,
                1, 6, 32'h11111111, 1, 2'b00, 1);
    tv[5]  = mk(0, 2'b10, 2'b10, 0, 0, 9, 32'hCAFEF00D,
                0, 0, 0, 0, 2'b00, 1);
    tv[6]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0,
                1, 9, 32'hCAFEF00D, 1, 2'b00, 1);
    tv[7]  = mk(0, 2'b01, 2'b01, 0, 32'hBAD0, 0, 0,
                0, 0, 0, 0, 2'b00, 1);
    tv[8]  = mk(0, 2'b01, 2'b00, 7, 32'hBAD1, 0, 0,
                0, 0, 0, 0, 2'b00, 1);
    tv[9]  = mk(0, 2'b00, 2'b00, 0, 0, 0, 0,
                0, 0, 0, 0, 2'b00, 1);
    // mid-operation reset with 3 queued
    tv[10] = mk(0, 2'b11, 2'b11, 10, 32'hA0, 11, 32'hB0,
                0, 0, 0, 0, 2'b00, 1);
    tv[11] = mk(0, 2'b11, 2'b11, 12, 32'hA1, 13, 32'hB1,
                1, 10, 32'hA0, 0, 2'b00, 1);
    tv[12] = mk(1, 2'b00, 2'b00, 0, 0, 0, 0,
                0, 0, 0, 0, 2'b00, 0);
    tv[13] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0,
                0, 0, 0, 0, 2'b00, 1);
    tv[14] = mk(0, 2'b11, 2'b11, 14, 32'hA2, 15, 32'hB2,
                0, 0, 0, 0, 2'b00, 1);
    tv[15] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0,
                1, 14, 32'hA2, 0, 2'b00, 1);
    tv[16] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0,
                1, 15, 32'hB2, 1, 2'b00, 1);
    tv[17] = mk(0, 2'b00, 2'b00, 0, 0, 0, 0,
                0, 0, 0, 0, 2'b00, 1);

    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      rst       = tv[i].rst;
      v_i       = tv[i].v;
      wb_i      = tv[i].wb;
      rd_num_i  = {tv[i].r1, tv[i].r0};
      rd_data_i = {tv[i].d1, tv[i].d0};
      @(negedge clk);
      check($sformatf("v%0d.wb_o", i),
            32'(wb_o), 32'(tv[i].ew));
      check($sformatf("v%0d.num", i),
            32'(wbr_num_o), 32'(tv[i].en));
      check($sformatf("v%0d.data", i),
            wb_data_o, tv[i].ed);
      check($sformatf("v%0d.ch", i),
            32'(wb_ch_o), 32'(tv[i].ec));
      if (tv[i].ck_s)
        check($sformatf("v%0d.stall", i),
              32'(stall_o), 32'(tv[i].es));
    end

    // contention: both channels push x1..x4
    for (int c = 0; c < 2; c++) begin
      nacc[c] = 0;
      nwr[c]  = 0;
      mc[c]   = 0;
    end
    tot  = 0;
    cyc  = 0;
    seen = 1'b0;
    wb_i = 2'b11;
    while (tot < 8 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
      for (int c = 0; c < 2; c++) begin
        v_i[c] = (nacc[c] < 4);
        rd_num_i[c*5 +: 5]    = 5'(nacc[c] + 1);
        rd_data_i[c*32 +: 32] = 32'h00C0_0000 |
                                32'(c << 8) |
                                32'(nacc[c] + 1);
      end
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        check($sformatf("cont.stall%0d", c),
              32'(stall_o[c]), 32'(mc[c] == 2));
        a[c] = v_i[c] && (mc[c] < 2);
      end
      if (wb_o) begin
        ch = tot % 2;
        check("cont.ch", 32'(wb_ch_o), 32'(ch));
        check("cont.num", 32'(wbr_num_o),
              32'(nwr[ch] + 1));
        check("cont.data", wb_data_o,
              32'h00C0_0000 | 32'(ch << 8) |
              32'(nwr[ch] + 1));
        check("cont.nonempty", 32'(mc[ch] > 0), 32'd1);
        if (stall_o[ch] && v_i[ch]) seen = 1'b1;
        nwr[ch]++;
        mc[ch]--;
        tot++;
      end
      for (int c = 0; c < 2; c++) begin
        if (a[c]) begin
          nacc[c]++;
          mc[c]++;
        end
      end
    end
    v_i = '0;
    check("cont.writes", 32'(tot), 32'd8);
    check("cont.cycles", 32'(cyc), 32'd9);
    check("cont.full_pop_seen", 32'(seen), 32'd1);
    check("cont.acc0", 32'(nacc[0]), 32'd4);
    check("cont.acc1", 32'(nacc[1]), 32'd4);

    @(posedge clk); #1;
    @(negedge clk);
    check("idle.wb_o", 32'(wb_o), 32'd0);
    check("idle.stall", 32'(stall_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
